// File: rtl/cache_pkg.sv
// Shared constants, line type and FSM encodings for the cache and backing-store controllers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

    localparam int OFFSET_BITS     = 6;
    localparam int LINE_BITS       = 512;
    localparam int WORD_BITS       = 32;
    localparam int WORDS_PER_BLOCK = LINE_BITS / WORD_BITS;
    localparam int MEM_DELAY       = 20;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_line_pattern.sv
// Default contents of an unwritten line: word w = base + 4*w, wrapping modulo 2**32.
// Latency: combinational.
// Backpressure: none.
module mem_line_pattern
    import cache_pkg::*;
(
    input  logic [31:0] base,
    output line_t       line
);

    always_comb begin
        line = '0;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
            line[w*WORD_BITS +: WORD_BITS] = base + 32'(4 * w);
        end
    end

endmodule

// File: rtl/main_memory_ctrl.sv
// Backing store for 512-bit line fills and write-backs, one request outstanding.
// Latency: response MEM_DELAY cycles after accept.
// Backpressure: response held stable until resp_ready; req_ready low outside IDLE.
module main_memory_ctrl #(
    parameter int MEM_DELAY     = cache_pkg::MEM_DELAY,
    parameter int LINE_IDX_BITS = 8,
    parameter int OFFSET_BITS   = cache_pkg::OFFSET_BITS,
    parameter int LINE_BITS     = cache_pkg::LINE_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [LINE_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_write,
    output logic [LINE_BITS-1:0] resp_rdata,
    output logic                 busy
);
    import cache_pkg::*;

    localparam int TAG_BITS  = 32 - OFFSET_BITS - LINE_IDX_BITS;
    localparam int NUM_LINES = 1 << LINE_IDX_BITS;
    localparam int CNT_BITS  = $clog2(MEM_DELAY + 1);

    mem_state_e                 state;
    logic [CNT_BITS-1:0]        cnt;
    logic                       lat_write;
    logic [31:0]                lat_addr;
    logic [LINE_BITS-1:0]       lat_wdata;

    logic [LINE_BITS-1:0]       data_mem [NUM_LINES];
    logic [TAG_BITS-1:0]        tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0]       written_flag;

    logic [LINE_IDX_BITS-1:0]   idx;
    logic [TAG_BITS-1:0]        lat_tag;
    logic                       access;
    logic                       hit;
    line_t                      pattern_line;

    assign idx     = lat_addr[OFFSET_BITS+LINE_IDX_BITS-1:OFFSET_BITS];
    assign lat_tag = lat_addr[31:OFFSET_BITS+LINE_IDX_BITS];
    assign access  = (state == ST_WAIT) && (cnt == CNT_BITS'(MEM_DELAY - 1));
    assign hit     = written_flag[idx] && (tag_mem[idx] == lat_tag);

    // lat_addr is stored line-aligned, so it is directly the pattern base
    mem_line_pattern u_pattern (
        .base (lat_addr),
        .line (pattern_line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            resp_valid   <= 1'b0;
            resp_write   <= 1'b0;
            resp_rdata   <= '0;
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            written_flag <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= {req_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        lat_wdata <= req_wdata;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (access) begin
                        resp_valid <= 1'b1;
                        resp_write <= lat_write;
                        if (lat_write) begin
                            written_flag[idx] <= 1'b1;
                            resp_rdata        <= '0;
                        end else begin
                            resp_rdata <= hit ? data_mem[idx] : pattern_line;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Line data and tags are not reset; written_flag alone decides whether they are valid
    always_ff @(posedge clk) begin
        if (access && lat_write) begin
            data_mem[idx] <= lat_wdata;
            tag_mem[idx]  <= lat_tag;
        end
    end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl with an accept-time scoreboard of expected responses.
module tb_main_memory_ctrl;

    localparam int MEM_DELAY = 20;

    typedef struct {
        logic         wr;
        logic [511:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [511:0] req_wdata = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic         resp_write;
    logic [511:0] resp_rdata;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t         exp_q[$];
    int           acc_times[$];
    logic [511:0] mdata[int];
    logic [31:0]  mbase[int];

    exp_t         mon_e;
    exp_t         mon_got;
    logic [31:0]  mon_base;
    int           mon_idx;

    main_memory_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_write (resp_write),
        .resp_rdata (resp_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] pat(input logic [31:0] base);
        logic [511:0] l;
        for (int w = 0; w < 16; w++) l[w*32 +: 32] = base + 32'(4 * w);
        return l;
    endfunction

    function automatic logic [511:0] seq_line(input logic [31:0] start);
        logic [511:0] l;
        for (int w = 0; w < 16; w++) l[w*32 +: 32] = start + 32'(w);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: predict on accept, compare on response handshake
    always @(posedge clk) begin
        cyc++;
        if (!rst && req_valid && req_ready) begin
            mon_base = req_addr & ~32'h3F;
            mon_idx  = int'((req_addr >> 6) & 32'hFF);
            if (req_write) begin
                mdata[mon_idx] = req_wdata;
                mbase[mon_idx] = mon_base;
                mon_e.wr   = 1'b1;
                mon_e.data = '0;
            end else begin
                mon_e.wr   = 1'b0;
                mon_e.data = (mbase.exists(mon_idx) && mbase[mon_idx] == mon_base)
                             ? mdata[mon_idx] : pat(mon_base);
            end
            exp_q.push_back(mon_e);
            acc_times.push_back(cyc);
        end
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                mon_got = exp_q.pop_front();
                chk("sb_rdata", resp_rdata, mon_got.data);
                chk("sb_write", resp_write, mon_got.wr);
            end
        end
    end

    always @(posedge rst) begin
        exp_q.delete();
        mdata.delete();
        mbase.delete();
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [511:0] wd);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready_before_accept", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        int lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, MEM_DELAY);
    endtask

    task automatic ack();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("resp_valid_after_ack", resp_valid, 0);
        chk("req_ready_after_ack", req_ready, 1);
        chk("busy_after_ack", busy, 0);
    endtask

    initial begin
        logic [511:0] snap;
        logic         stray;
        int           t;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_write", resp_write, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // 1: fill of a never-written line
        issue(1'b0, 32'h0000_1040, '0);
        chk("t1_busy_in_wait", busy, 1);
        wait_resp("t1");
        chk("t1_word0", resp_rdata[31:0], 32'h0000_1040);
        chk("t1_word15", resp_rdata[511:480], 32'h0000_107C);
        chk("t1_resp_write", resp_write, 0);
        ack();

        // 2: write-back then read with a non-zero offset
        issue(1'b1, 32'h0000_2000, seq_line(32'hA000_0000));
        wait_resp("t2w");
        chk("t2_ack_write", resp_write, 1);
        chk("t2_ack_rdata", resp_rdata, 0);
        ack();
        issue(1'b0, 32'h0000_203C, '0);
        wait_resp("t2r");
        chk("t2_word15", resp_rdata[511:480], 32'hA000_000F);
        ack();

        // 3: aliasing at idx 0x80
        issue(1'b1, 32'h0000_2000, seq_line(32'hA000_0000));
        wait_resp("t3w0");
        ack();
        issue(1'b1, 32'h0000_6000, seq_line(32'hB000_0000));
        wait_resp("t3w1");
        ack();
        issue(1'b0, 32'h0000_2000, '0);
        wait_resp("t3r0");
        chk("t3_old_word0", resp_rdata[31:0], 32'h0000_2000);
        ack();
        issue(1'b0, 32'h0000_6000, '0);
        wait_resp("t3r1");
        chk("t3_new_word0", resp_rdata[31:0], 32'hB000_0000);
        ack();

        // 4: backpressure in RESP with a stray request pulse
        issue(1'b0, 32'h0000_1000, '0);
        wait_resp("t4");
        snap = resp_rdata;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = (i == 3);
            req_write = 1'b0;
            req_addr  = 32'h0000_5000;
            @(posedge clk);
            #1;
            if (i == 9) begin
                chk("t4_hold_valid", resp_valid, 1);
                chk("t4_hold_rdata", resp_rdata, snap);
                chk("t4_hold_req_ready", req_ready, 0);
            end else if (!resp_valid || resp_rdata !== snap || req_ready) begin
                chk("t4_hold_stable", 0, 1);
            end
        end
        req_valid = 1'b0;
        ack();
        stray = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (resp_valid) stray = 1'b1;
        end
        chk("t4_no_stray_resp", stray, 0);
        chk("t4_queue_empty", exp_q.size(), 0);

        // 5: reset during WAIT of a write
        issue(1'b1, 32'h0000_3000, seq_line(32'hC000_0000));
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_busy_in_rst", busy, 0);
        chk("t5_req_ready_in_rst", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (resp_valid) stray = 1'b1;
        end
        chk("t5_no_resp", stray, 0);
        issue(1'b0, 32'h0000_3000, '0);
        wait_resp("t5r0");
        chk("t5_word0", resp_rdata[31:0], 32'h0000_3000);
        ack();
        issue(1'b0, 32'h0000_6000, '0);
        wait_resp("t5r1");
        chk("t5_reverted_word0", resp_rdata[31:0], 32'h0000_6000);
        ack();

        // 6: address wrap, then back-to-back spacing
        issue(1'b0, 32'hFFFF_FFC0, '0);
        wait_resp("t6");
        chk("t6_word0", resp_rdata[31:0], 32'hFFFF_FFC0);
        chk("t6_word15", resp_rdata[511:480], 32'hFFFF_FFFC);
        ack();
        @(negedge clk);
        acc_times.delete();
        resp_ready = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h0000_0040;
        req_valid  = 1'b1;
        t = 0;
        while (acc_times.size() < 3 && t < 300) begin
            @(negedge clk);
            t++;
        end
        req_valid = 1'b0;
        while (exp_q.size() > 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("t6_accepts", acc_times.size(), 3);
        chk("t6_spacing1", acc_times[1] - acc_times[0], MEM_DELAY + 2);
        chk("t6_spacing2", acc_times[2] - acc_times[1], MEM_DELAY + 2);
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
